// File: rtl/led_fade_if.sv
// Pattern-in / PWM-out bundle for the LED fade stage.
// The master side is the upstream pattern generator; the slave side is led_fade.
interface led_fade_if;
  logic [7:0] led_in;
  logic [7:0] led_pwm;
  logic       fade_active;

  modport master (output led_in, input led_pwm, fade_active);
  modport slave  (input led_in, output led_pwm, fade_active);
endinterface

// File: rtl/led_fade.sv
// Comet-tail LED fader: lit inputs drive full brightness, dropped ones fade linearly via 15-step PWM.
// Define LED_FADE_GAMMA_EN to map levels through a perceptual gamma table before the PWM compare.
module led_fade #(
  parameter logic [23:0] DECAY_MAX = 24'd100_000
) (
  input  logic     sys_clk,
  input  logic     sys_rst_n,
  led_fade_if.slave bus
);

  logic [3:0]  lvl [8];
  logic [3:0]  duty [8];
  logic [3:0]  pwm_cnt;
  logic [23:0] dcnt;
  logic        tick;
  logic        any_active;
  logic [7:0]  led_pwm_q;
  logic        fade_active_q;

`ifdef LED_FADE_GAMMA_EN
  function automatic logic [3:0] gamma(input logic [3:0] l);
    logic [3:0] g;
    case (l)
      4'd0, 4'd1, 4'd2:   g = 4'd0;
      4'd3, 4'd4, 4'd5:   g = 4'd1;
      4'd6, 4'd7:         g = 4'd2;
      4'd8:               g = 4'd3;
      4'd9:               g = 4'd4;
      4'd10:              g = 4'd5;
      4'd11:              g = 4'd6;
      4'd12:              g = 4'd8;
      4'd13:              g = 4'd10;
      4'd14:              g = 4'd12;
      default:            g = 4'd15;
    endcase
    return g;
  endfunction
`endif

  assign tick = (dcnt == DECAY_MAX);

  always_comb begin
    any_active = 1'b0;
    for (int i = 0; i < 8; i++) begin
`ifdef LED_FADE_GAMMA_EN
      duty[i] = gamma(lvl[i]);
`else
      duty[i] = lvl[i];
`endif
      any_active = any_active | (lvl[i] != 4'd0);
    end
  end

  // A lit input always wins over a coincident decay tick, so the comet head never dims.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      pwm_cnt       <= 4'd0;
      dcnt          <= 24'd0;
      led_pwm_q     <= 8'h00;
      fade_active_q <= 1'b0;
      for (int i = 0; i < 8; i++) lvl[i] <= 4'd0;
    end else begin
      pwm_cnt       <= (pwm_cnt == 4'd14) ? 4'd0 : pwm_cnt + 4'd1;
      dcnt          <= tick ? 24'd0 : dcnt + 24'd1;
      fade_active_q <= any_active;
      for (int i = 0; i < 8; i++) begin
        if (bus.led_in[i])
          lvl[i] <= 4'd15;
        else if (tick && (lvl[i] != 4'd0))
          lvl[i] <= lvl[i] - 4'd1;
        led_pwm_q[i] <= (duty[i] > pwm_cnt);
      end
    end
  end

  assign bus.led_pwm     = led_pwm_q;
  assign bus.fade_active = fade_active_q;

endmodule

// File: tb/tb_led_fade.sv
// Scoreboard bench for led_fade: directed scenarios plus random patterns against a cycle-count model.
module tb_led_fade;

  localparam int DM = 3;

  typedef struct packed {
    logic [7:0] pwm;
    logic       fa;
  } exp_t;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;

  led_fade_if bus ();

  led_fade #(.DECAY_MAX(24'(DM))) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Model: brightness per channel plus the number of clocks since reset released.
  int lvl_m [8];
  int cyc_m = 0;
  int gtab [16] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 5, 6, 8, 10, 12, 15};

  function automatic int duty_of(input int l);
`ifdef LED_FADE_GAMMA_EN
    return gtab[l];
`else
    return l;
`endif
  endfunction

  task automatic applyStimulus(input logic rst_n, input logic [7:0] pat);
    exp_t e;
    int   phase;
    bit   tk;
    @(negedge sys_clk);
    sys_rst_n  = rst_n;
    bus.led_in = pat;
    e.pwm = 8'h00;
    e.fa  = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) lvl_m[i] = 0;
      cyc_m = 0;
    end else begin
      phase = cyc_m % 15;
      tk    = (cyc_m % (DM + 1)) == DM;
      for (int i = 0; i < 8; i++) begin
        e.pwm[i] = duty_of(lvl_m[i]) > phase;
        if (lvl_m[i] != 0) e.fa = 1'b1;
        if (pat[i])                     lvl_m[i] = 15;
        else if (tk && lvl_m[i] > 0)    lvl_m[i] = lvl_m[i] - 1;
      end
      cyc_m++;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: every clock the DUT presents a new output pair; pop and compare.
  always @(posedge sys_clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (bus.led_pwm !== e.pwm) begin
        bad++;
        $display("[TB] FAIL led_pwm t=%0t got=%h want=%h", $time, bus.led_pwm, e.pwm);
      end
      total++;
      if (bus.fade_active !== e.fa) begin
        bad++;
        $display("[TB] FAIL fade_active t=%0t got=%b want=%b", $time, bus.fade_active, e.fa);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] pat;
    int guard;
    bus.led_in = 8'h00;

    // Reset with a lit input held, then release and watch it stay full on.
    repeat (3) applyStimulus(1'b0, 8'h01);
    repeat (20) applyStimulus(1'b1, 8'h01);

    // Fade out of channel 0 through all levels.
    repeat (10) applyStimulus(1'b1, 8'h01);
    repeat (75) applyStimulus(1'b1, 8'h00);

    // Collision: relight channel 2 exactly on a tick while it sits at level 5.
    applyStimulus(1'b1, 8'h04);
    guard = 0;
    while (!(lvl_m[2] == 5 && (cyc_m % (DM + 1)) == DM) && guard < 100) begin
      applyStimulus(1'b1, 8'h00);
      guard++;
    end
    total++;
    if (guard >= 100) begin
      bad++;
      $display("[TB] FAIL collision_setup got=%0d want=<100", guard);
    end
    applyStimulus(1'b1, 8'h04);
    repeat (30) applyStimulus(1'b1, 8'h00);

    // Rotating one-hot pattern, two full laps.
    for (int k = 0; k < 16; k++) begin
      pat = 8'h01;
      pat = pat << (k % 8);
      repeat (8) applyStimulus(1'b1, pat);
    end

    // Reset mid-fade with inputs idle.
    applyStimulus(1'b0, 8'h00);
    repeat (20) applyStimulus(1'b1, 8'h00);

    // Random patterns with occasional resets.
    for (int n = 0; n < 800; n++) begin
      pat = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
      applyStimulus(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1, pat);
    end

    @(posedge sys_clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
